// File: rtl/bcast_fanout_unit_pkg.sv
// Collective flit format shared by the fan-out and reduce units.
// Field offsets are relative to the top of the payload.
package bcast_fanout_unit_pkg;

  localparam int PayloadWidthDef = 32;
  localparam int HdrWidth = 50;

  localparam int OpOfs = 0;
  localparam int OpW = 4;
  localparam int AlgOfs = 4;
  localparam int AlgW = 2;
  localparam int TagOfs = 6;
  localparam int TagW = 8;
  localparam int CtxOfs = 14;
  localparam int CtxW = 8;
  localparam int RankOfs = 22;
  localparam int RankW = 9;
  localparam int SrcOfs = 31;
  localparam int DstOfs = 40;
  localparam int CoordW = 9;
  localparam int ValidOfs = 49;

  localparam int opPos = PayloadWidthDef + OpOfs;
  localparam int algPos = PayloadWidthDef + AlgOfs;
  localparam int tagPos = PayloadWidthDef + TagOfs;
  localparam int ctxPos = PayloadWidthDef + CtxOfs;
  localparam int rankPos = PayloadWidthDef + RankOfs;
  localparam int srcPos = PayloadWidthDef + SrcOfs;
  localparam int dstPos = PayloadWidthDef + DstOfs;
  localparam int ValidBitPos = PayloadWidthDef + ValidOfs;
  localparam int FlitWidth = PayloadWidthDef + HdrWidth;

  localparam logic [OpW-1:0] ShortBcast = 4'h1;
  localparam logic [OpW-1:0] Scatter = 4'h2;
  localparam logic [OpW-1:0] ShortAllReduce = 4'h3;
  localparam logic [OpW-1:0] LongBcast = 4'h4;
  localparam logic [OpW-1:0] ReduceOp = 4'h5;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_EMIT
  } fan_state_e;

endpackage

// File: rtl/bcast_fanout_unit_if.sv
// Fan-out handshake bundle: in_* from the collective engine,
// out_* to router injection, plus done/copies status.
interface bcast_fanout_unit_if
  import bcast_fanout_unit_pkg::*;
#(
  parameter int PayloadWidth = 32,
  parameter int lg_numprocs = 3
) ();
  localparam int FW = PayloadWidth + HdrWidth;
  localparam int NP = 1 << lg_numprocs;

  logic [FW-1:0] in_flit;
  logic [NP-1:0] in_mask;
  logic in_valid;
  logic in_rdy;
  logic [FW-1:0] out_flit;
  logic out_valid;
  logic out_rdy;
  logic done;
  logic [lg_numprocs:0] copies;

  modport master (
    output in_flit, in_mask, in_valid, out_rdy,
    input in_rdy, out_flit, out_valid, done, copies
  );

  modport slave (
    input in_flit, in_mask, in_valid, out_rdy,
    output in_rdy, out_flit, out_valid, done, copies
  );
endinterface

// File: rtl/bcast_fanout_unit_lowest_set_idx.sv
// Priority encoder: index of lowest set bit of mask,
// any = mask non-zero.
module bcast_fanout_unit_lowest_set_idx #(
  parameter int W = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  assign any = |mask;
endmodule

// File: rtl/bcast_fanout_unit.sv
// Replicates one collective flit into one copy per rank in mask.
// Ports: clk, rst (async active-low), bus (slave: in/out handshakes, done, copies).
module bcast_fanout_unit
  import bcast_fanout_unit_pkg::*;
#(
  parameter logic [2:0] rank_z = 3'b0,
  parameter logic [2:0] rank_y = 3'b0,
  parameter logic [2:0] rank_x = 3'b0,
  parameter int lg_numprocs = 3,
  parameter int PayloadWidth = 32
) (
  input logic clk,
  input logic rst,
  bcast_fanout_unit_if.slave bus
);
  localparam int NP = 1 << lg_numprocs;
  localparam int FW = PayloadWidth + HdrWidth;
  localparam int CW = lg_numprocs + 1;
  localparam int AlgPos = PayloadWidth + AlgOfs;
  localparam int SrcPos = PayloadWidth + SrcOfs;
  localparam int DstPos = PayloadWidth + DstOfs;
  localparam int ValidPos = PayloadWidth + ValidOfs;

  localparam logic [CoordW-1:0] SelfRank = {rank_z, rank_y, rank_x};
  localparam logic [lg_numprocs-1:0] OwnIdx =
    SelfRank[lg_numprocs-1:0];
  localparam logic [NP-1:0] OwnBit = NP'(1) << OwnIdx;

  fan_state_e state_q, state_d;
  logic [NP-1:0] pend_q, pend_d;
  logic [NP-1:0] pend_clr, mask_eff;
  logic [FW-1:0] flit_q, flit_d, out_f;
  logic pass_q, pass_d, done_q;
  logic [lg_numprocs-1:0] tgt;
  logic tgt_any;
  logic hs_out, last, acc;
  logic [CW-1:0] pop;

  bcast_fanout_unit_lowest_set_idx #(
    .W (NP),
    .IW(lg_numprocs)
  ) u_enc (
    .mask(pend_q),
    .idx (tgt),
    .any (tgt_any)
  );

  assign bus.out_valid =
    (state_q == ST_EMIT) & (pass_q | tgt_any);
  assign hs_out = bus.out_valid & bus.out_rdy;
  assign pend_clr = pend_q & ~(NP'(1) << tgt);
  assign last = hs_out & (pass_q | ~|pend_clr);
  // Ready on the final handshake lets the next flit follow with no bubble.
  assign bus.in_rdy = rst & ((state_q == ST_IDLE) | last);
  assign acc = bus.in_valid & bus.in_rdy;
  assign mask_eff = bus.in_mask & ~OwnBit;
  assign bus.done = done_q;

  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    pass_d = pass_q;
    flit_d = flit_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_EMIT: begin
        if (hs_out) begin
          pend_d = pend_clr;
          if (last) begin
            state_d = ST_IDLE;
            pass_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (acc) begin
      flit_d = bus.in_flit;
      // Invalid flits are swallowed without output.
      if (bus.in_flit[ValidPos]) begin
        state_d = ST_EMIT;
        pend_d = mask_eff;
        pass_d = ~|mask_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pend_q <= '0;
      pass_q <= 1'b0;
      flit_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      pass_q <= pass_d;
      flit_q <= flit_d;
      done_q <= last;
    end
  end

  always_comb begin
    out_f = '0;
    if (state_q == ST_EMIT) begin
      out_f = flit_q;
      out_f[ValidPos] = 1'b1;
      out_f[AlgPos +: AlgW] = '0;
      if (!pass_q) begin
        out_f[DstPos +: CoordW] = CoordW'(tgt);
        out_f[SrcPos +: CoordW] = SelfRank;
      end
    end
  end

  assign bus.out_flit = out_f;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NP; i++) begin
      pop = pop + CW'(pend_q[i]);
    end
  end

  assign bus.copies = pass_q ? CW'(1) : pop;
endmodule

// File: tb/tb_bcast_fanout_unit.sv
// Bench for bcast_fanout_unit: directed scenarios plus
// randomized flits checked against a queue-based model.
module tb_bcast_fanout_unit;
  import bcast_fanout_unit_pkg::*;

  localparam int PW = 32;
  localparam int FW = PW + HdrWidth;
  localparam int NP = 8;
  localparam int VP = PW + ValidOfs;
  localparam int AP = PW + AlgOfs;
  localparam int DP = PW + DstOfs;
  localparam int SP = PW + SrcOfs;

  logic clk;
  logic rst;
  int n_checks;
  int n_pass;

  logic [FW-1:0] in_q[$];
  logic [NP-1:0] mk_q[$];
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] obs_q[$];
  int cps_q[$];

  bcast_fanout_unit_if #(.PayloadWidth(PW), .lg_numprocs(3)) bus ();

  bcast_fanout_unit #(
    .rank_z(3'b0), .rank_y(3'b0), .rank_x(3'b0),
    .lg_numprocs(3), .PayloadWidth(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] rand_flit();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  // One expected copy; r < 0 means pass-through.
  function automatic logic [FW-1:0] mk_copy(
    input logic [FW-1:0] f, input int r);
    logic [FW-1:0] e;
    e = f;
    e[VP] = 1'b1;
    e[AP +: 2] = 2'b00;
    if (r >= 0) begin
      e[DP +: 9] = 9'(r);
      e[SP +: 9] = 9'd0;
    end
    return e;
  endfunction

  // This node is rank 0, so its own bit is bit 0.
  function automatic void model(
    input logic [FW-1:0] f, input logic [NP-1:0] m);
    logic [NP-1:0] em;
    if (!f[VP]) return;
    em = m;
    em[0] = 1'b0;
    if (em == '0) exp_q.push_back(mk_copy(f, -1));
    else
      for (int r = 0; r < NP; r++)
        if (em[r]) exp_q.push_back(mk_copy(f, r));
  endfunction

  // Drives in_q/mk_q, records accepted copies in obs_q.
  task automatic run(input int mode, input int exp_total,
    output int dones, output int gaps, output int viol,
    output int rdy_low, output bit tmo);
    int idx, tail, cyc;
    bit prev_stall;
    logic [FW-1:0] prev_f;
    logic ov;
    idx = 0; tail = 0; cyc = 0;
    dones = 0; gaps = 0; viol = 0; rdy_low = 0; tmo = 0;
    prev_stall = 0; prev_f = '0;
    obs_q.delete(); cps_q.delete();
    while (tail < 4) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin tmo = 1; break; end
      case (mode)
        0: bus.out_rdy = 1'b1;
        1: bus.out_rdy = cyc[0];
        default: bus.out_rdy = 1'($urandom_range(0, 1));
      endcase
      if (idx < in_q.size()) begin
        bus.in_valid = 1'b1;
        bus.in_flit = in_q[idx];
        bus.in_mask = mk_q[idx];
      end else bus.in_valid = 1'b0;
      #1;
      ov = bus.out_valid;
      if (prev_stall && (ov !== 1'b1 || bus.out_flit !== prev_f))
        viol++;
      prev_stall = ov && !bus.out_rdy;
      prev_f = bus.out_flit;
      if (ov && bus.out_rdy) begin
        obs_q.push_back(bus.out_flit);
        cps_q.push_back(int'(bus.copies));
      end
      if (!ov && obs_q.size() > 0 && obs_q.size() < exp_total)
        gaps++;
      if (bus.done) dones++;
      if (!bus.in_rdy) rdy_low++;
      if (bus.in_valid && bus.in_rdy) idx++;
      if (idx == in_q.size() && obs_q.size() >= exp_total) tail++;
    end
    bus.in_valid = 1'b0;
    bus.out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_rdy !== 1'b0)
      $display("FAIL rst_in_rdy got %b exp 0", bus.in_rdy);
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.copies !== 4'd0)
      $display("FAIL rst_out got v=%b c=%0d exp v=0 c=0",
        bus.out_valid, bus.copies);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0)
      $display("FAIL rst_done got %b exp 0", bus.done);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_rdy !== 1'b1)
      $display("FAIL rel_in_rdy got %b exp 1", bus.in_rdy);
    else n_pass++;
  endtask

  task automatic test_fixed_mask();
    int dn, gp, vi, rl;
    bit tmo;
    int dsts[4];
    logic [FW-1:0] f;
    dsts[0] = 1; dsts[1] = 2; dsts[2] = 4; dsts[3] = 7;
    f = rand_flit(); f[VP] = 1'b1;
    in_q.delete(); mk_q.delete(); exp_q.delete();
    in_q.push_back(f); mk_q.push_back(8'b1001_0110);
    model(f, 8'b1001_0110);
    run(0, exp_q.size(), dn, gp, vi, rl, tmo);
    n_checks++;
    if (tmo || obs_q.size() != 4)
      $display("FAIL fix_count got %0d exp 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_q[i][DP +: 9] !== 9'(dsts[i]) ||
          obs_q[i][SP +: 9] !== 9'd0 || cps_q[i] != 4 - i)
        $display("FAIL fix_dst%0d got %0d cp %0d exp %0d cp %0d",
          i, obs_q[i][DP +: 9], cps_q[i], dsts[i], 4 - i);
      else n_pass++;
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL fix_flit%0d got %h exp %h",
          i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (dn != 1 || gp != 0)
      $display("FAIL fix_done got done=%0d gaps=%0d exp 1 0", dn, gp);
    else n_pass++;
  endtask

  task automatic test_stall();
    int dn, gp, vi, rl;
    bit tmo;
    logic [FW-1:0] f;
    f = rand_flit(); f[VP] = 1'b1;
    in_q.delete(); mk_q.delete(); exp_q.delete();
    in_q.push_back(f); mk_q.push_back(8'b1001_0110);
    model(f, 8'b1001_0110);
    run(1, exp_q.size(), dn, gp, vi, rl, tmo);
    n_checks++;
    if (tmo || obs_q.size() != exp_q.size())
      $display("FAIL stall_count got %0d exp %0d",
        obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL stall_flit%0d got %h exp %h",
          i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (vi != 0 || dn != 1)
      $display("FAIL stall_hold got viol=%0d done=%0d exp 0 1", vi, dn);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    int dn, gp, vi, rl;
    bit tmo;
    logic [FW-1:0] f;
    f = rand_flit(); f[VP] = 1'b1;
    in_q.delete(); mk_q.delete(); exp_q.delete();
    in_q.push_back(f); mk_q.push_back(8'b0000_0001);
    model(f, 8'b0000_0001);
    run(0, 1, dn, gp, vi, rl, tmo);
    n_checks++;
    if (tmo || obs_q.size() != 1 || cps_q[0] != 1)
      $display("FAIL pass_count got %0d exp 1", obs_q.size());
    else n_pass++;
    n_checks++;
    if (obs_q[0][DP +: 9] !== f[DP +: 9])
      $display("FAIL pass_dst got %0d exp %0d",
        obs_q[0][DP +: 9], f[DP +: 9]);
    else n_pass++;
    n_checks++;
    if (obs_q[0] !== exp_q[0] || dn != 1)
      $display("FAIL pass_flit got %h exp %h", obs_q[0], exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dn, gp, vi, rl;
    bit tmo;
    logic [FW-1:0] f;
    in_q.delete(); mk_q.delete(); exp_q.delete();
    f = rand_flit(); f[VP] = 1'b1;
    in_q.push_back(f); mk_q.push_back(8'b0000_0110);
    model(f, 8'b0000_0110);
    f = rand_flit(); f[VP] = 1'b1;
    in_q.push_back(f); mk_q.push_back(8'b0000_1000);
    model(f, 8'b0000_1000);
    run(0, exp_q.size(), dn, gp, vi, rl, tmo);
    n_checks++;
    if (tmo || obs_q.size() != 3)
      $display("FAIL b2b_count got %0d exp 3", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][DP +: 9] !== 9'(i + 1))
        $display("FAIL b2b_flit%0d got %h exp %h",
          i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (gp != 0 || dn != 2)
      $display("FAIL b2b_flow got gaps=%0d done=%0d exp 0 2", gp, dn);
    else n_pass++;
  endtask

  task automatic test_drop();
    int dn, gp, vi, rl;
    bit tmo;
    logic [FW-1:0] f;
    f = rand_flit(); f[VP] = 1'b0;
    in_q.delete(); mk_q.delete(); exp_q.delete();
    in_q.push_back(f); mk_q.push_back(8'b0110_1010);
    model(f, 8'b0110_1010);
    run(0, 0, dn, gp, vi, rl, tmo);
    n_checks++;
    if (obs_q.size() != 0 || dn != 0 || exp_q.size() != 0)
      $display("FAIL drop_out got %0d copies %0d done exp 0 0",
        obs_q.size(), dn);
    else n_pass++;
    n_checks++;
    if (rl != 0 || tmo)
      $display("FAIL drop_rdy got %0d low cycles exp 0", rl);
    else n_pass++;
  endtask

  task automatic test_reset_mid_emit();
    int seen, dn;
    logic [FW-1:0] f;
    f = rand_flit(); f[VP] = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b1;
    bus.in_flit = f;
    bus.in_mask = 8'b0000_1110;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (bus.copies !== 4'd2 || bus.out_valid !== 1'b1)
      $display("FAIL mid_pre got c=%0d v=%b exp 2 1",
        bus.copies, bus.out_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.copies !== 4'd0 ||
        bus.in_rdy !== 1'b0)
      $display("FAIL mid_rst got v=%b c=%0d r=%b exp 0 0 0",
        bus.out_valid, bus.copies, bus.in_rdy);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0; dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (bus.out_valid) seen++;
      if (bus.done) dn++;
    end
    n_checks++;
    if (seen != 0 || dn != 0 || bus.in_rdy !== 1'b1)
      $display("FAIL mid_after got out=%0d done=%0d exp 0 0", seen, dn);
    else n_pass++;
  endtask

  task automatic test_random();
    int dn, gp, vi, rl, nvalid;
    bit tmo;
    logic [FW-1:0] f;
    logic [NP-1:0] m;
    in_q.delete(); mk_q.delete(); exp_q.delete();
    nvalid = 0;
    for (int k = 0; k < 30; k++) begin
      f = rand_flit();
      f[VP] = ($urandom_range(0, 7) != 0);
      m = NP'($urandom());
      if (f[VP]) nvalid++;
      in_q.push_back(f); mk_q.push_back(m);
      model(f, m);
    end
    run(2, exp_q.size(), dn, gp, vi, rl, tmo);
    n_checks++;
    if (tmo || obs_q.size() != exp_q.size())
      $display("FAIL rnd_count got %0d exp %0d",
        obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL rnd_flit%0d got %h exp %h",
          i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (dn != nvalid || vi != 0)
      $display("FAIL rnd_done got done=%0d viol=%0d exp %0d 0",
        dn, vi, nvalid);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_flit = '0;
    bus.in_mask = '0;
    bus.out_rdy = 1'b0;
    test_reset();
    test_fixed_mask();
    test_stall();
    test_passthrough();
    test_back_to_back();
    test_drop();
    test_reset_mid_emit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
